// File: rtl/dmem_pkg.sv
// Shared types for the data-memory load/store unit.
// Size encodings, FSM states and the wait-counter width.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_be_array.sv
// Word-wide storage with per-byte write enables.
// Synchronous write, combinational read, contents not reset.
module dmem_be_array #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_lsu.sv
// Load/store front end with wait states over dmem_be_array.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = ADDR_W + 2;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             l_we;
  logic [1:0]       l_size;
  logic             l_uns;
  logic [AW-1:0]    l_addr;
  logic [31:0]      l_wdata;

  logic [1:0]  off;
  logic [3:0]  be_lane;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] rword;
  logic [31:0] rshift;
  logic [31:0] ldata;
  logic        mis;
  logic        fire;

  // Lane steering; misaligned low bits are simply dropped here.
  always_comb begin
    off     = 2'b00;
    be_lane = 4'b1111;
    wlane   = l_wdata;
    unique case (1'b1)
      (l_size == SZ_BYTE): begin
        off     = l_addr[1:0];
        be_lane = 4'b0001 << l_addr[1:0];
        wlane   = {4{l_wdata[7:0]}};
      end
      (l_size == SZ_HALF): begin
        off     = {l_addr[1], 1'b0};
        be_lane = l_addr[1] ? 4'b1100 : 4'b0011;
        wlane   = {2{l_wdata[15:0]}};
      end
      default: begin
        off     = 2'b00;
        be_lane = 4'b1111;
        wlane   = l_wdata;
      end
    endcase
  end

  assign rshift = rword >> {off, 3'b000};

  always_comb begin
    ldata = rshift;
    unique case (1'b1)
      (l_size == SZ_BYTE):
        ldata = {{24{~l_uns & rshift[7]}}, rshift[7:0]};
      (l_size == SZ_HALF):
        ldata = {{16{~l_uns & rshift[15]}}, rshift[15:0]};
      default:
        ldata = rshift;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = ((l_size == SZ_HALF) && l_addr[0]) ||
               (l_size[1] && (l_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign fire = (state == S_WAIT) && (cnt == '0);
  assign be   = (fire && l_we && !mis) ? be_lane : 4'b0000;

  dmem_be_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clk),
    .be    (be),
    .addr  (l_addr[AW-1:2]),
    .wdata (wlane),
    .rdata (rword)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      l_we      <= 1'b0;
      l_size    <= SZ_BYTE;
      l_uns     <= 1'b0;
      l_addr    <= '0;
      l_wdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            l_we      <= req_we;
            l_size    <= req_size;
            l_uns     <= req_unsigned;
            l_addr    <= req_addr;
            l_wdata   <= req_wdata;
            cnt       <= CNT_W'(WAIT_CYCLES);
            state     <= S_WAIT;
            req_ready <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= mis;
            rsp_rdata <= (l_we || mis) ? 32'h0 : ldata;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one instance with no wait states,
// one with three, sharing clock and reset.
module tb_dmem_lsu;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        v0 = 0, we0 = 0, u0 = 0;
  logic [1:0]  sz0 = 0;
  logic [7:0]  a0 = 0;
  logic [31:0] wd0 = 0;
  logic        rdy0, rv0, er0;
  logic [31:0] rd0;

  logic        v1 = 0, we1 = 0, u1 = 0;
  logic [1:0]  sz1 = 0;
  logic [7:0]  a1 = 0;
  logic [31:0] wd1 = 0;
  logic        rdy1, rv1, er1;
  logic [31:0] rd1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(6), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_size(sz0), .req_unsigned(u0), .req_addr(a0),
    .req_wdata(wd0), .rsp_valid(rv0), .rsp_rdata(rd0),
    .rsp_err(er0)
  );

  dmem_lsu #(.ADDR_W(6), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_size(sz1), .req_unsigned(u1), .req_addr(a1),
    .req_wdata(wd1), .rsp_valid(rv1), .rsp_rdata(rd1),
    .rsp_err(er1)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic acc(input bit d, input bit we,
                     input logic [1:0] sz, input bit uns,
                     input logic [7:0] addr,
                     input logic [31:0] wd,
                     output logic [31:0] rd, output logic er,
                     output int lat, output int nlow);
    int k;
    bit got;
    @(negedge clk);
    if (d) begin
      v1 = 1; we1 = we; sz1 = sz; u1 = uns; a1 = addr; wd1 = wd;
    end else begin
      v0 = 1; we0 = we; sz0 = sz; u0 = uns; a0 = addr; wd0 = wd;
    end
    k = 0; got = 0; nlow = 0; rd = 'x; er = 1'bx;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        if (d) v1 = 0; else v0 = 0;
      end
      if (!(d ? rdy1 : rdy0)) nlow++;
      if (d ? rv1 : rv0) begin
        got = 1;
        rd = d ? rd1 : rd0;
        er = d ? er1 : er0;
      end
    end
    check("rsp_timeout", 32'(got), 32'd1);
    lat = k - 1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, nlow;

  initial begin
    int k, p1, p2, pulses;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(rdy0), 32'd1);
    check("rst_valid", 32'(rv0), 32'd0);
    check("rst_rdata", rd0, 32'h0);
    check("rst_err", 32'(er0), 32'd0);
    check("rst_ready3", 32'(rdy1), 32'd1);
    @(negedge clk);
    rst_n = 1;

    acc(0, 1, W, 0, 8'h08, 32'hDEADBEEF, rd, er, lat, nlow);
    check("st_w_rdata", rd, 32'h0);
    check("st_w_err", 32'(er), 32'd0);
    check("st_w_lat", 32'(lat), 32'd1);
    check("st_w_nlow", 32'(nlow), 32'd1);

    acc(0, 0, W, 0, 8'h08, 32'h0, rd, er, lat, nlow);
    check("ld_w_08", rd, 32'hDEADBEEF);
    check("ld_w_lat", 32'(lat), 32'd1);

    acc(0, 1, B, 0, 8'h09, 32'hAAAAAA7F, rd, er, lat, nlow);
    check("st_b_rdata", rd, 32'h0);
    acc(0, 0, B, 0, 8'h0B, 32'h0, rd, er, lat, nlow);
    check("ld_bs_0b", rd, 32'hFFFFFFDE);
    acc(0, 0, B, 1, 8'h0B, 32'h0, rd, er, lat, nlow);
    check("ld_bu_0b", rd, 32'h000000DE);
    acc(0, 0, W, 1, 8'h08, 32'h0, rd, er, lat, nlow);
    check("ld_w_after_b", rd, 32'hDEAD7FEF);
    acc(0, 0, H, 0, 8'h0A, 32'h0, rd, er, lat, nlow);
    check("ld_hs_0a", rd, 32'hFFFFDEAD);
    acc(0, 0, H, 1, 8'h0A, 32'h0, rd, er, lat, nlow);
    check("ld_hu_0a", rd, 32'h0000DEAD);

    acc(0, 1, W, 0, 8'h0C, 32'h0, rd, er, lat, nlow);
    acc(0, 1, H, 0, 8'h0C, 32'hFFFF8001, rd, er, lat, nlow);
    acc(0, 0, B, 0, 8'h0D, 32'h0, rd, er, lat, nlow);
    check("ld_bs_0d", rd, 32'hFFFFFF80);
    acc(0, 0, W, 0, 8'h0C, 32'h0, rd, er, lat, nlow);
    check("ld_w_0c", rd, 32'h00008001);
    acc(0, 0, 2'b11, 0, 8'h08, 32'h0, rd, er, lat, nlow);
    check("ld_rsvd_08", rd, 32'hDEAD7FEF);

`ifdef DMEM_MISALIGN_TRAP_EN
    acc(0, 0, W, 0, 8'h0A, 32'h0, rd, er, lat, nlow);
    check("mis_ld_rdata", rd, 32'h0);
    check("mis_ld_err", 32'(er), 32'd1);
    check("mis_ld_lat", 32'(lat), 32'd1);
    acc(0, 0, H, 0, 8'h09, 32'h0, rd, er, lat, nlow);
    check("mis_h_err", 32'(er), 32'd1);
    acc(0, 1, W, 0, 8'h0A, 32'h55555555, rd, er, lat, nlow);
    check("mis_st_err", 32'(er), 32'd1);
    acc(0, 0, W, 0, 8'h08, 32'h0, rd, er, lat, nlow);
    check("mis_st_nowr", rd, 32'hDEAD7FEF);
    check("ok_err", 32'(er), 32'd0);
`else
    acc(0, 0, W, 0, 8'h0A, 32'h0, rd, er, lat, nlow);
    check("mis_ld_rdata", rd, 32'hDEAD7FEF);
    check("mis_ld_err", 32'(er), 32'd0);
    acc(0, 0, H, 0, 8'h09, 32'h0, rd, er, lat, nlow);
    check("mis_h_align", rd, 32'h00007FEF);
    acc(0, 1, W, 0, 8'h0A, 32'h55555555, rd, er, lat, nlow);
    acc(0, 0, W, 0, 8'h08, 32'h0, rd, er, lat, nlow);
    check("mis_st_align", rd, 32'h55555555);
`endif

    acc(1, 1, W, 0, 8'h10, 32'h11223344, rd, er, lat, nlow);
    check("w3_st_lat", 32'(lat), 32'd4);
    check("w3_st_nlow", 32'(nlow), 32'd4);
    @(negedge clk);
    check("w3_one_pulse", 32'(rv1), 32'd0);
    acc(1, 0, W, 0, 8'h10, 32'h0, rd, er, lat, nlow);
    check("w3_ld_10", rd, 32'h11223344);
    check("w3_ld_lat", 32'(lat), 32'd4);

    // request held through WAIT: second acceptance only once IDLE
    @(negedge clk);
    v1 = 1; we1 = 0; sz1 = H; u1 = 1; a1 = 8'h12; wd1 = 0;
    k = 0; p1 = -1; p2 = -1;
    while (p2 < 0 && k < 60) begin
      @(negedge clk);
      k++;
      if (rv1) begin
        if (p1 < 0) p1 = k;
        else p2 = k;
      end
    end
    v1 = 0;
    check("held_gap", 32'(p2 - p1), 32'd5);
    check("held_rdata", rd1, 32'h00001122);

    // reset during WAIT of a store aborts it
    @(negedge clk);
    v1 = 1; we1 = 1; sz1 = W; a1 = 8'h10; wd1 = 32'hAAAAAAAA;
    @(negedge clk);
    v1 = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    check("rst_mid_valid", 32'(rv1), 32'd0);
    check("rst_mid_ready", 32'(rdy1), 32'd1);
    @(negedge clk);
    rst_n = 1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rv1) pulses++;
    end
    check("rst_no_rsp", 32'(pulses), 32'd0);
    check("rst_ready_after", 32'(rdy1), 32'd1);
    acc(1, 0, W, 0, 8'h10, 32'h0, rd, er, lat, nlow);
    check("rst_no_write", rd, 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised 32-bit data memory with a load/store front end for the MIPS core.
- Byte-addressed; supports byte, halfword and word accesses, byte-lane write enables and sign/zero-extended loads.
- Valid/ready request handshake and a programmable wait-state counter, so the core can be tested against slow memory.
- Sits between the core's memory stage and the data store.

Parameters:
- ADDR_W, 6, word-address bits; depth = 2**ADDR_W words.
- WAIT_CYCLES, 0, extra wait states per access; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W+2  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle completion pulse, for loads and stores.
- rsp_rdata  out  32  load result, extended; 0 for stores.
- rsp_err  out  1  misaligned access (only when the optional feature is enabled).

Behaviour:
- Reset values: FSM = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0. Memory contents are not reset.
- Reset asserted mid-access: the pending access is aborted with no write and no response.
- FSM states: IDLE, WAIT.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid = 1, latch we, size, unsigned, addr and wdata.
  - Load counter with WAIT_CYCLES and go to WAIT.
- WAIT:
  - req_ready = 0; request inputs are ignored.
  - Each edge with counter != 0: decrement the counter.
  - Edge with counter == 0: perform the access, set rsp_valid = 1 for one cycle, return to IDLE.
- Latency:
  - Acceptance at edge E gives access and response at edge E+WAIT_CYCLES+1.
  - rsp_valid is high during the following cycle.
  - req_ready is already 1 in that cycle, so back-to-back requests are allowed.
- There is no response backpressure; the consumer must sample rsp_* while rsp_valid = 1.
- Endianness: little-endian. Byte offset addr[1:0] = 0 selects bits [7:0]; word index = addr[ADDR_W+1:2].
- Stores:
  - Byte writes only lane addr[1:0], with data req_wdata[7:0].
  - Halfword writes lanes {addr[1],0} and {addr[1],1}, with data req_wdata[15:0].
  - Word writes all four lanes.
  - Unselected lanes are unchanged.
- Loads:
  - Select the lane(s) as for stores, then extend per req_unsigned. Word loads ignore req_unsigned.
  - rsp_rdata holds its value until the next response; the next store response sets it to 0.
- Misalignment without the optional feature: ignored low bits are forced to 0, i.e. addr[0] for halfword and addr[1:0] for word.
- Read-after-write: a load accepted after a store's response returns the stored data. No same-cycle hazard is possible, because there is only one access in flight.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with addr[0] = 1, or a word with addr[1:0] != 0, completes with the normal latency and rsp_err = 1 alongside rsp_valid.
  - No memory write occurs and rsp_rdata = 0.
  - rsp_err = 0 for all other responses.
- Undefined: rsp_err is tied to 0, and misaligned addresses are aligned down as described under Behaviour.

Decomposition:
- Package dmem_pkg contains:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state enum;
  - WAIT counter width constant (4 bits).
- Sub-module dmem_be_array holds the storage:
  - 2**ADDR_W x 32 array;
  - 4-bit byte write enable;
  - synchronous write, combinational read.
- dmem_lsu owns the FSM, lane steering and extension.

Test Plan:
- Store word 0xDEADBEEF at addr 0x08, then load word 0x08 → rsp_rdata = 0xDEADBEEF; with WAIT_CYCLES = 0, rsp_valid arrives 1 cycle after acceptance.
- After the above: store byte 0x7F to 0x09, then signed load byte 0x0B → 0xFFFFFFDE; load word 0x08 → 0xDEAD7FEF.
- Signed halfword load at 0x0A → 0xFFFFDEAD; unsigned → 0x0000DEAD.
- WAIT_CYCLES = 3: req_ready low for exactly 4 cycles after acceptance, one rsp_valid pulse; a request held on req_valid during WAIT is not accepted until IDLE.
- Word load at 0x0A:
  - with DMEM_MISALIGN_TRAP_EN: rsp_err = 1, rsp_rdata = 0, and a misaligned store leaves memory unchanged;
  - without it: the load returns word 0x08.
- Assert rst_n low during WAIT of a store to 0x10 → no rsp_valid, a later load of 0x10 returns its prior contents, req_ready = 1 after reset.
